// File: rtl/match_controller.sv
// Match-level sequencer for pong: serve delay, post-point pause, pause/resume,
// score keeping and first-to-WIN_SCORE game over.
module match_controller #(
    parameter int WIN_SCORE    = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int PAUSE_FRAMES = 90
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       start,
    input  logic       tick,
    input  logic       p1_point,
    input  logic       p2_point,
    output logic       ball_run,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [1:0] p1_score,
    output logic [1:0] p2_score,
    output logic [1:0] winner,
    output logic [2:0] state
);

    localparam int MAX_FRAMES = (SERVE_FRAMES > PAUSE_FRAMES) ? SERVE_FRAMES : PAUSE_FRAMES;
    localparam int CW         = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
    localparam logic [CW-1:0] PAUSE_LAST = CW'(PAUSE_FRAMES - 1);
    localparam logic [1:0]    WIN        = 2'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_SERVE_WAIT  = 3'd1,
        S_PLAY        = 3'd2,
        S_PAUSED      = 3'd3,
        S_POINT_PAUSE = 3'd4,
        S_GAME_OVER   = 3'd5
    } state_e;

    state_e          r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_p1_score;
    logic [1:0]      r_p2_score;
    logic [1:0]      r_winner;
    logic            r_serve_dir;

    logic [1:0]      w_p1_next;
    logic [1:0]      w_p2_next;

    assign w_p1_next = r_p1_score + 2'd1;
    assign w_p2_next = r_p2_score + 2'd1;

    // NOTE: every register here is written with <= so all next-state terms read pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_p1_score  <= 2'd0;
            r_p2_score  <= 2'd0;
            r_winner    <= 2'b00;
            r_serve_dir <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_SERVE_WAIT;
                        r_cnt       <= '0;
                        r_p1_score  <= 2'd0;
                        r_p2_score  <= 2'd0;
                        r_winner    <= 2'b00;
                        r_serve_dir <= 1'b0;
                    end
                end
                S_SERVE_WAIT: begin
                    if (tick) begin
                        if (r_cnt == SERVE_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_PLAY;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    // start outranks a coincident point, which is simply dropped
                    if (start) begin
                        r_state <= S_PAUSED;
                    end else if (p1_point && p2_point) begin
                        r_cnt   <= '0;
                        r_state <= S_POINT_PAUSE;
                    end else if (p1_point) begin
                        r_p1_score  <= w_p1_next;
                        r_serve_dir <= 1'b1;
                        r_cnt       <= '0;
                        if (w_p1_next == WIN) begin
                            r_winner <= 2'b01;
                            r_state  <= S_GAME_OVER;
                        end else begin
                            r_state <= S_POINT_PAUSE;
                        end
                    end else if (p2_point) begin
                        r_p2_score  <= w_p2_next;
                        r_serve_dir <= 1'b0;
                        r_cnt       <= '0;
                        if (w_p2_next == WIN) begin
                            r_winner <= 2'b10;
                            r_state  <= S_GAME_OVER;
                        end else begin
                            r_state <= S_POINT_PAUSE;
                        end
                    end
                end
                S_PAUSED: begin
                    if (start) r_state <= S_PLAY;
                end
                S_POINT_PAUSE: begin
                    if (tick) begin
                        if (r_cnt == PAUSE_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_PLAY;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_GAME_OVER: begin
                    if (start) begin
                        r_state    <= S_SERVE_WAIT;
                        r_cnt      <= '0;
                        r_p1_score <= 2'd0;
                        r_p2_score <= 2'd0;
                        r_winner   <= 2'b00;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign state      = r_state;
    assign ball_run   = (r_state == S_PLAY);
    assign ball_reset = !((r_state == S_PLAY) || (r_state == S_PAUSED));
    assign serve_dir  = r_serve_dir;
    assign p1_score   = r_p1_score;
    assign p2_score   = r_p2_score;
    assign winner     = r_winner;

endmodule

// File: tb/tb_match_controller.sv
// Directed scoreboard bench for match_controller: expected outputs are queued
// before each stimulus step and popped for comparison one cycle later.
module tb_match_controller;

    localparam int WIN_SCORE    = 3;
    localparam int SERVE_FRAMES = 60;
    localparam int PAUSE_FRAMES = 90;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic       p1_point = 1'b0;
    logic       p2_point = 1'b0;
    logic       ball_run;
    logic       ball_reset;
    logic       serve_dir;
    logic [1:0] p1_score;
    logic [1:0] p2_score;
    logic [1:0] winner;
    logic [2:0] state;

    always #5 clk = ~clk;

    match_controller #(
        .WIN_SCORE   (WIN_SCORE),
        .SERVE_FRAMES(SERVE_FRAMES),
        .PAUSE_FRAMES(PAUSE_FRAMES)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .start     (start),
        .tick      (tick),
        .p1_point  (p1_point),
        .p2_point  (p2_point),
        .ball_run  (ball_run),
        .ball_reset(ball_reset),
        .serve_dir (serve_dir),
        .p1_score  (p1_score),
        .p2_score  (p2_score),
        .winner    (winner),
        .state     (state)
    );

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic       run;
        logic       rst;
        logic       dir;
        logic [1:0] s1;
        logic [1:0] s2;
        logic [1:0] win;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic cmp(input string tag, input string field, input logic [2:0] obs, input logic [2:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] st, input logic run, input logic rst,
                        input logic dir, input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] win);
        exp_t e;
        e.tag = tag; e.st = st; e.run = run; e.rst = rst;
        e.dir = dir; e.s1 = s1; e.s2 = s2; e.win = win;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_checks++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            cmp(e.tag, "state",      state,      e.st);
            cmp(e.tag, "ball_run",   ball_run,   e.run);
            cmp(e.tag, "ball_reset", ball_reset, e.rst);
            cmp(e.tag, "serve_dir",  serve_dir,  e.dir);
            cmp(e.tag, "p1_score",   p1_score,   e.s1);
            cmp(e.tag, "p2_score",   p2_score,   e.s2);
            cmp(e.tag, "winner",     winner,     e.win);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
    task automatic step(input logic s, input logic t, input logic a, input logic b);
        start = s; tick = t; p1_point = a; p2_point = b;
        @(posedge clk);
        #1;
        start = 1'b0; tick = 1'b0; p1_point = 1'b0; p2_point = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        repeat (n) step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic go(input string tag, input logic s, input logic t, input logic a, input logic b,
                      input logic [2:0] st, input logic run, input logic rst, input logic dir,
                      input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] win);
        push(tag, st, run, rst, dir, s1, s2, win);
        step(s, t, a, b);
        check_out();
    endtask

    task automatic hold(input string tag, input logic [2:0] st, input logic run, input logic rst,
                        input logic dir, input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] win);
        push(tag, st, run, rst, dir, s1, s2, win);
        check_out();
    endtask

    initial begin
        #2;
        hold("reset", 3'd0, 0, 1, 0, 2'd0, 2'd0, 2'b00);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Serve delay
        go("idle_tick",   0, 1, 0, 0, 3'd0, 0, 1, 0, 2'd0, 2'd0, 2'b00);
        go("start",       1, 0, 0, 0, 3'd1, 0, 1, 0, 2'd0, 2'd0, 2'b00);
        go("sw_start",    1, 0, 0, 0, 3'd1, 0, 1, 0, 2'd0, 2'd0, 2'b00);
        go("sw_point",    0, 0, 1, 0, 3'd1, 0, 1, 0, 2'd0, 2'd0, 2'b00);
        run_ticks(SERVE_FRAMES - 1);
        go("sw_59",       0, 0, 0, 0, 3'd1, 0, 1, 0, 2'd0, 2'd0, 2'b00);
        go("serve",       0, 1, 0, 0, 3'd2, 1, 0, 0, 2'd0, 2'd0, 2'b00);

        // P2 wins 3-0
        go("p2_pt1",      0, 0, 0, 1, 3'd4, 0, 1, 0, 2'd0, 2'd1, 2'b00);
        run_ticks(PAUSE_FRAMES - 1);
        go("pp_start",    1, 0, 0, 0, 3'd4, 0, 1, 0, 2'd0, 2'd1, 2'b00);
        go("pp_point",    0, 0, 1, 0, 3'd4, 0, 1, 0, 2'd0, 2'd1, 2'b00);
        go("pp1_end",     0, 1, 0, 0, 3'd2, 1, 0, 0, 2'd0, 2'd1, 2'b00);
        go("p2_pt2",      0, 0, 0, 1, 3'd4, 0, 1, 0, 2'd0, 2'd2, 2'b00);
        run_ticks(PAUSE_FRAMES - 1);
        go("pp2_end",     0, 1, 0, 0, 3'd2, 1, 0, 0, 2'd0, 2'd2, 2'b00);
        go("p2_pt3",      0, 0, 0, 1, 3'd5, 0, 1, 0, 2'd0, 2'd3, 2'b10);
        go("go_p1",       0, 0, 1, 0, 3'd5, 0, 1, 0, 2'd0, 2'd3, 2'b10);
        go("go_tick",     0, 1, 0, 0, 3'd5, 0, 1, 0, 2'd0, 2'd3, 2'b10);
        go("go_restart",  1, 0, 0, 0, 3'd1, 0, 1, 0, 2'd0, 2'd0, 2'b00);
        run_ticks(SERVE_FRAMES - 1);
        go("serve2",      0, 1, 0, 0, 3'd2, 1, 0, 0, 2'd0, 2'd0, 2'b00);

        // P1 point and pause
        go("p1_pt",       0, 0, 1, 0, 3'd4, 0, 1, 1, 2'd1, 2'd0, 2'b00);
        run_ticks(PAUSE_FRAMES - 1);
        go("pp3_89",      0, 0, 0, 0, 3'd4, 0, 1, 1, 2'd1, 2'd0, 2'b00);
        go("pp3_end",     0, 1, 0, 0, 3'd2, 1, 0, 1, 2'd1, 2'd0, 2'b00);

        // Simultaneous points, start with a point
        go("both_pts",    0, 0, 1, 1, 3'd4, 0, 1, 1, 2'd1, 2'd0, 2'b00);
        run_ticks(PAUSE_FRAMES - 1);
        go("pp4_end",     0, 1, 0, 0, 3'd2, 1, 0, 1, 2'd1, 2'd0, 2'b00);
        go("start_pt",    1, 0, 0, 1, 3'd3, 0, 0, 1, 2'd1, 2'd0, 2'b00);

        // Paused behaviour
        go("paused_tick", 0, 1, 0, 0, 3'd3, 0, 0, 1, 2'd1, 2'd0, 2'b00);
        go("paused_p1",   0, 0, 1, 0, 3'd3, 0, 0, 1, 2'd1, 2'd0, 2'b00);
        go("paused_both", 0, 0, 1, 1, 3'd3, 0, 0, 1, 2'd1, 2'd0, 2'b00);
        go("resume",      1, 0, 0, 0, 3'd2, 1, 0, 1, 2'd1, 2'd0, 2'b00);
        go("pause2",      1, 0, 0, 0, 3'd3, 0, 0, 1, 2'd1, 2'd0, 2'b00);
        go("resume2",     1, 0, 0, 0, 3'd2, 1, 0, 1, 2'd1, 2'd0, 2'b00);

        // Asynchronous reset mid point pause
        go("p2_pt_mid",   0, 0, 0, 1, 3'd4, 0, 1, 0, 2'd1, 2'd1, 2'b00);
        run_ticks(40);
        #3 rst_n = 1'b0;
        #1;
        hold("async_rst", 3'd0, 0, 1, 0, 2'd0, 2'd0, 2'b00);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_ticks(SERVE_FRAMES - 1);
        go("idle_60",     0, 1, 0, 0, 3'd0, 0, 1, 0, 2'd0, 2'd0, 2'b00);

        // P1 wins 3-0
        go("start3",      1, 0, 0, 0, 3'd1, 0, 1, 0, 2'd0, 2'd0, 2'b00);
        run_ticks(SERVE_FRAMES - 1);
        go("serve3",      0, 1, 0, 0, 3'd2, 1, 0, 0, 2'd0, 2'd0, 2'b00);
        for (int i = 1; i <= WIN_SCORE; i++) begin
            if (i < WIN_SCORE) begin
                go("p1_run", 0, 0, 1, 0, 3'd4, 0, 1, 1, 2'(i), 2'd0, 2'b00);
                run_ticks(PAUSE_FRAMES - 1);
                go("p1_run_end", 0, 1, 0, 0, 3'd2, 1, 0, 1, 2'(i), 2'd0, 2'b00);
            end else begin
                go("p1_win", 0, 0, 1, 0, 3'd5, 0, 1, 1, 2'(i), 2'd0, 2'b01);
            end
        end
        go("go_p2",       0, 0, 0, 1, 3'd5, 0, 1, 1, 2'd3, 2'd0, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
